// File: rtl/vedic_pkg.sv
// vedic_pkg: shared types and widths for the vedic_mul_arbiter block.
//   state_t : sequencer states (IDLE -> MUL -> RESP -> IDLE)
//   OP_W    : operand width of the shared multiplier
//   PROD_W  : full product width (no truncation)
package vedic_pkg;

  localparam int OP_W   = 3;
  localparam int PROD_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req        : request vector, one bit per requester
//   last_grant : index of the previously granted requester
//   en         : arbitration enable; gnt is zero when low
//   gnt        : one-hot grant (or zero when nothing requested / disabled)
// The search starts at last_grant+1 and wraps modulo NREQ, so the requester
// just served has the lowest priority on the next round.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last_grant,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  logic found;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    if (en) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && req[(int'(last_grant) + k) % NREQ]) begin
          gnt[(int'(last_grant) + k) % NREQ] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vedic3bit.sv
// vedic3bit: 3x3 unsigned combinational multiplier using the Urdhva
// Tiryagbhyam (vertical and crosswise) column scheme.
//   a, b : 3-bit unsigned operands
//   p    : 6-bit unsigned product
module vedic3bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [5:0] p
);

  // Column sums. Each column adds its crosswise partial products plus the
  // carry bits of the previous column; the LSB of each sum is a product bit.
  logic [1:0] s1;
  logic [2:0] s2;
  logic [2:0] s3;
  logic [1:0] s4;

  always_comb begin
    s1 = 2'(a[1] & b[0]) + 2'(a[0] & b[1]);
    s2 = 3'(a[2] & b[0]) + 3'(a[1] & b[1]) + 3'(a[0] & b[2]) + 3'(s1[1]);
    s3 = 3'(a[2] & b[1]) + 3'(a[1] & b[2]) + 3'(s2[2:1]);
    s4 = 2'(a[2] & b[2]) + s3[2:1];
    p  = {s4, s3[0], s2[0], s1[0], a[0] & b[0]};
  end

endmodule

// File: rtl/vedic_mul_arbiter.sv
// vedic_mul_arbiter: shares one vedic3bit multiplier among NREQ requesters.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : per-requester operand-pair valid
//   req_a/req_b : per-requester 3-bit operands, requester i at [3i+2:3i]
//   req_ready   : one-hot accept strobe (IDLE only)
//   rsp_valid   : product available (RESP state)
//   rsp_id      : owner of rsp_mul
//   rsp_mul     : 6-bit unsigned product
//   rsp_ready   : consumer accepts the response
//   busy        : high whenever the sequencer is not IDLE
//   ops_done    : wrapping count of completed responses
// One operation takes IDLE (accept) -> MUL (multiply) -> RESP (hold until
// handshake); operations never overlap.
module vedic_mul_arbiter
  import vedic_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [OP_W*NREQ-1:0] req_a,
  input  logic [OP_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [PROD_W-1:0]    rsp_mul,
  input  logic                 rsp_ready,
  output logic                 busy,
  output logic [7:0]           ops_done
);

  state_t              state, state_nxt;
  logic [NREQ-1:0]     gnt;
  logic                accept;
  logic                handshake;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     id_q;
  logic [ID_W-1:0]     win_id;
  logic [OP_W-1:0]     win_a, win_b;
  logic [OP_W-1:0]     op_a, op_b;
  logic [PROD_W-1:0]   mul_c;
  logic [PROD_W-1:0]   mul_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .en         (state == IDLE),
    .gnt        (gnt)
  );

  vedic3bit u_mul (
    .a (op_a),
    .b (op_b),
    .p (mul_c)
  );

  assign accept    = |gnt;
  assign handshake = (state == RESP) && rsp_ready;

  // Grant is one-hot, so OR-ing the masked fields selects the winner.
  always_comb begin
    win_id = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_id = win_id | ID_W'(i);
        win_a  = win_a | req_a[OP_W*i +: OP_W];
        win_b  = win_b | req_b[OP_W*i +: OP_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MUL;
      MUL:     state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too because rsp_id/rsp_mul are
  // driven straight from them and must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      id_q       <= '0;
      mul_q      <= '0;
      last_grant <= ID_W'(NREQ - 1);
      ops_done   <= '0;
    end else begin
      if (accept) begin
        op_a       <= win_a;
        op_b       <= win_b;
        id_q       <= win_id;
        last_grant <= win_id;
      end
      if (state == MUL) mul_q <= mul_c;
      if (handshake)    ops_done <= ops_done + 8'd1;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign rsp_mul   = mul_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// tb_vedic_mul_arbiter: directed self-checking bench for vedic_mul_arbiter
// (NREQ=4). Inputs are driven 1 ns after the rising edge; outputs are
// sampled 1 ns after that, well away from the next edge.
module tb_vedic_mul_arbiter;

  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [3*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0] req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [5:0]      rsp_mul;
  logic            rsp_ready;
  logic            busy;
  logic [7:0]      ops_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [7:0] exp_ops = 8'd0;

  vedic_mul_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_mul   (rsp_mul),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One full operation on a single requester with rsp_ready high:
  // accept, MUL, RESP+handshake -- exactly three edges.
  task automatic run_op(input int id, input int a, input int b, input int exp_mul,
                        input string tag);
    req_valid         = 4'(1 << id);
    req_a[3*id +: 3]  = 3'(a);
    req_b[3*id +: 3]  = 3'(b);
    settle();
    check({tag, " ready"}, 32'(req_ready), 32'(1 << id));
    tick();
    // Garble inputs after acceptance; they must have no effect.
    req_valid = '0;
    req_a     = '1;
    req_b     = '1;
    settle();
    check({tag, " mul busy"}, 32'(busy), 32'd1);
    check({tag, " mul no rsp"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_id"}, 32'(rsp_id), 32'(id));
    check({tag, " rsp_mul"}, 32'(rsp_mul), 32'(exp_mul));
    tick();
    exp_ops = exp_ops + 8'd1;
    check({tag, " ops_done"}, 32'(ops_done), 32'(exp_ops));
    check({tag, " idle"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Reset state
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_id", 32'(rsp_id), 32'd0);
    check("rst rsp_mul", 32'(rsp_mul), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ops_done", 32'(ops_done), 32'd0);

    // First operation: requester 0, 1*2
    rsp_ready = 1'b1;
    run_op(0, 1, 2, 2, "first");

    // Sequential products on requester 1, one result every 3 cycles
    run_op(1, 2, 4, 8,  "seq0");
    run_op(1, 4, 5, 20, "seq1");
    run_op(1, 5, 6, 30, "seq2");
    run_op(1, 6, 7, 42, "seq3");
    run_op(1, 7, 7, 49, "seq4");

    // Backpressure: requester 2 (5*3) wins over 3 (last grant was 1);
    // requester 3 stays valid and must not be granted while stalled.
    rsp_ready  = 1'b0;
    req_valid  = 4'b1100;
    req_a      = {3'd2, 3'd5, 3'd0, 3'd0};
    req_b      = {3'd2, 3'd3, 3'd0, 3'd0};
    settle();
    check("bp grant2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1000;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp rsp_mul", 32'(rsp_mul), 32'd15);
      check("bp rsp_id", 32'(rsp_id), 32'd2);
      check("bp no grant", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    settle();
    check("bp still valid", 32'(rsp_valid), 32'd1);
    tick();
    exp_ops = exp_ops + 8'd1;
    check("bp ops_done", 32'(ops_done), 32'(exp_ops));
    check("bp grant3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    tick();
    check("bp3 rsp_id", 32'(rsp_id), 32'd3);
    check("bp3 rsp_mul", 32'(rsp_mul), 32'd4);
    tick();
    exp_ops = exp_ops + 8'd1;
    check("bp3 ops_done", 32'(ops_done), 32'(exp_ops));

    // Reset mid-operation: requester 1 accepted, reset hits in MUL
    req_valid = 4'b0010;
    req_a     = {3'd0, 3'd0, 3'd3, 3'd0};
    req_b     = {3'd0, 3'd0, 3'd3, 3'd0};
    settle();
    check("mid grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    settle();
    check("mid in mul", 32'(busy), 32'd1);
    rst_n = 1'b0;
    settle();
    exp_ops = 8'd0;
    check("mid busy", 32'(busy), 32'd0);
    check("mid rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid ops_done", 32'(ops_done), 32'd0);
    check("mid rsp_mul", 32'(rsp_mul), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      check("mid no rsp", 32'(rsp_valid), 32'd0);
      tick();
    end

    // Fairness: all valid, requester i sends (i+1)*3; first grant is 0
    req_valid = 4'b1111;
    req_a     = {3'd4, 3'd3, 3'd2, 3'd1};
    req_b     = {3'd3, 3'd3, 3'd3, 3'd3};
    for (int k = 0; k < 8; k++) begin
      settle();
      check("fair grant", 32'(req_ready), 32'(1 << (k % 4)));
      tick();
      check("fair mul ready", 32'(req_ready), 32'd0);
      tick();
      check("fair rsp_id", 32'(rsp_id), 32'(k % 4));
      check("fair rsp_mul", 32'(rsp_mul), 32'(((k % 4) + 1) * 3));
      tick();
      exp_ops = exp_ops + 8'd1;
      check("fair ops_done", 32'(ops_done), 32'(exp_ops));
    end
    req_valid = '0;

    // Counter wrap: 256 operations since the last reset
    for (int i = 8; i < 256; i++)
      run_op(0, i % 8, (i / 8) % 8, (i % 8) * ((i / 8) % 8), "wrap");
    check("wrap zero", 32'(ops_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vedic_mul_arbiter.md
# vedic_mul_arbiter

Round-robin arbiter and sequencer that shares a single `vedic3bit` combinational multiplier among `NREQ` requesters. Each requester presents a 3-bit operand pair with a valid/ready handshake. The block grants one requester at a time, registers the operands, and captures the 6-bit product. It returns the product, tagged with the requester index, on a single response channel with backpressure.

## Interface
- `NREQ`, 4, number of requesters; 2..8.
- `ID_W`, `$clog2(NREQ)`, width of the requester tag; derived, do not override.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset; clears all state immediately.
- `req_valid`  in  NREQ  bit i: requester i presents an operand pair.
- `req_a`  in  3*NREQ  operand A of requester i at bits [3i+2:3i].
- `req_b`  in  3*NREQ  operand B of requester i at bits [3i+2:3i].
- `req_ready`  out  NREQ  one-hot or zero; bit i high means requester i is accepted this cycle.
- `rsp_valid`  out  1  product available.
- `rsp_id`  out  ID_W  index of the requester that owns `rsp_mul`.
- `rsp_mul`  out  6  A*B, unsigned.
- `rsp_ready`  in  1  consumer accepts the response.
- `busy`  out  1  high in every state except IDLE.
- `ops_done`  out  8  count of completed responses; wraps 255->0.

## Operation
- The FSM has three states: IDLE, MUL and RESP.
- **IDLE**
  - If any `req_valid` is high, the arbiter picks winner w round-robin, searching from `last_grant+1` modulo NREQ.
  - `req_ready[w]` is driven high combinationally in the same cycle.
  - On the clock edge, operands are latched into `op_a`/`op_b`, `id_q` is set to w, `last_grant` is set to w, and the FSM moves to MUL.
  - If no `req_valid` is high, the FSM stays in IDLE and `req_ready` is 0.
- **MUL**
  - The shared `vedic3bit` computes `op_a*op_b` combinationally.
  - On the edge, the product goes to `mul_q` and the FSM moves to RESP.
  - `req_ready` is 0.
- **RESP**
  - `rsp_valid` is 1, `rsp_mul` is `mul_q` and `rsp_id` is `id_q`.
  - These outputs hold stable until `rsp_ready` is sampled high.
  - On the accepting edge, `ops_done` increments and the FSM returns to IDLE.
  - `req_ready` is 0 throughout RESP.
- Arithmetic is unsigned; the product is always 6 bits wide with no truncation (max 7*7=49).
- Requester inputs are sampled only in the accept cycle. Changes to `req_a`/`req_b` after acceptance have no effect.
- A requester dropping `req_valid` before it is granted is legal and loses nothing.
- Arbitration is fair: a continuously valid requester is granted within NREQ accepts.

## Timing
- **Reset values:** state=IDLE, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_mul`=0, `busy`=0, `ops_done`=0, `last_grant`=NREQ-1, so requester 0 has first priority.
- **Latency:** accept at edge T; MUL during cycle T+1; `rsp_valid` high from cycle T+2.
- **Throughput:** the best case is one operation per 3 cycles with `rsp_ready` tied high. Each stall cycle in RESP adds one cycle.
- **Next accept:** a new grant happens no earlier than the cycle after the response handshake. There is no overlap between operations.
- **Simultaneous valids:** exactly one grant per accept cycle; others wait.
- **Reset mid-operation:** an in-flight operation is discarded, no response is produced, and outputs go to their reset values asynchronously.
- **`ops_done` wrap:** 255 + 1 = 0 with no flag.

## Structure
- Package `vedic_pkg` holds:
  - the state enum (IDLE, MUL, RESP);
  - `OP_W`=3 and `PROD_W`=6.
- Sub-module `rr_arbiter` (parameter NREQ):
  - inputs: `req` vector, `last_grant`, `en`;
  - output: one-hot `gnt`;
  - purely combinational.
- Top level instantiates one `rr_arbiter` and one existing `vedic3bit`, both unmodified, plus the FSM and registers.

## Test plan
- **Reset:** after reset release, all outputs are 0. Then requester 0 sends A=1, B=2 -> `req_ready[0]` pulses once; `rsp_valid` rises 2 cycles later with `rsp_id`=0 and `rsp_mul`=2; `ops_done`=1.
- **Sequential products:** pairs (2,4), (4,5), (5,6), (6,7), (7,7) on requester 1 with `rsp_ready`=1 -> products 8, 20, 30, 42, 49; `rsp_id`=1; one result every 3 cycles.
- **Fairness:** all 4 requesters continuously valid, requester i sending A=i+1, B=3 -> grant order 0,1,2,3,0,...; products 3, 6, 9, 12 tagged with ids 0..3.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles in RESP -> `rsp_valid`, `rsp_mul`, `rsp_id` stable; `req_ready` stays 0; no new grant until the handshake.
- **Reset mid-operation:** assert `rst_n`=0 in the MUL cycle -> no response is ever produced; `busy`=0 immediately; the first grant after release goes to requester 0.
- **Counter wrap:** run 256 operations -> `ops_done` returns to 0 after the 256th handshake.
